game_controller: RTL

Top-level sequencer for the five-LED reaction game. Owns the game state machine and drives the pattern generator's mode inputs (`Run`, `Normal`, `FlashCorrect`, `FlashWrong`) and level (`lvl`). Judges each player press against the generator's sweep position `S`, and paces flash sequences by counting the generator's `Cycle` pulses. Sits between the button pad and the pattern generator; the LED serializer is downstream of the generator and is not touched.

---
 rtl/game_pkg.sv | 43 ++++
 rtl/game_controller_btn_edge.sv | 26 ++
 rtl/game_controller.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the reaction game: controller states, the
// decoded generator mode bundle, and the hit positions seen by the pattern generator.
package game_pkg;

    localparam int LVL_W                = 3;
    localparam int DEF_MAX_LVL          = 4;
    localparam int DEF_FLASH_CYCLES     = 6;
    localparam int DEF_LIVES            = 3;
    localparam logic [2:0] DEF_HIT_S0   = 3'd2;
    localparam logic [2:0] DEF_HIT_S1   = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_CORRECT,
        ST_WRONG,
        ST_WIN
    } state_t;

    typedef struct packed {
        logic run;
        logic normal;
        logic flash_correct;
        logic flash_wrong;
        logic win;
    } ctrl_t;

    // Generator mode lines for each controller state.
    function automatic ctrl_t decode(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            ST_IDLE:    c.run = 1'b1;
            ST_PLAY:    begin c.run = 1'b1; c.normal = 1'b1; end
            ST_CORRECT: c.flash_correct = 1'b1;
            ST_WRONG:   c.flash_wrong = 1'b1;
            ST_WIN:     begin c.flash_correct = 1'b1; c.win = 1'b1; end
            default:    c.run = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/game_controller_btn_edge.sv
// Button conditioner: two-flop synchronizer followed by a registered
// rising-edge detector giving one clk-wide pulse per press.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic sync1, sync2, sync2_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            sync2_d <= sync2;
            press   <= sync2 & ~sync2_d;
        end
    end

endmodule

// File: rtl/game_controller.sv
// Reaction-game sequencer: judges presses against the sweep position and
// paces flashes by generator Cycle ticks. Optional lives feature: GAME_LIVES_EN.
//
//   state   | meaning
//   IDLE    | generator idle blink, waiting for a press to start
//   PLAY    | sweep running, next press is judged
//   CORRECT | hit flash, level advances on exit
//   WRONG   | miss flash, level (or a life) is lost on exit
//   WIN     | hit at top level, press returns to IDLE
module game_controller
    import game_pkg::*;
#(
    parameter int         MAX_LVL      = DEF_MAX_LVL,
    parameter int         FLASH_CYCLES = DEF_FLASH_CYCLES,
    parameter logic [2:0] HIT_S0       = DEF_HIT_S0,
    parameter logic [2:0] HIT_S1       = DEF_HIT_S1,
    parameter int         LIVES        = DEF_LIVES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn,
    input  logic             Cycle,
    input  logic [2:0]       S,
    output logic             Run,
    output logic             Normal,
    output logic             FlashCorrect,
    output logic             FlashWrong,
    output logic [LVL_W-1:0] lvl,
    output logic             win,
    output logic [1:0]       lives
);

    localparam logic [LVL_W-1:0] MAX_LVL_V = LVL_W'(MAX_LVL);
    localparam logic [3:0]       FLASH_V   = 4'(FLASH_CYCLES);
    localparam logic [1:0]       LIVES_V   = 2'(LIVES);

    logic       press;
    state_t     state;
    ctrl_t      ctrl;
    logic [3:0] flash_cnt;
    logic       hit;
    logic       flash_done;

    btn_edge u_btn (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .press (press)
    );

    assign hit        = (S == HIT_S0) || (S == HIT_S1);
    assign flash_done = (flash_cnt == FLASH_V);

`ifdef GAME_LIVES_EN
    logic [1:0] lives_q;
    logic       last_life;
    assign last_life = (lives_q == 2'd1);
    assign lives     = lives_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lives_q <= LIVES_V;
        end else if (state == ST_IDLE && press) begin
            lives_q <= LIVES_V;
        end else if (state == ST_WRONG && flash_done) begin
            lives_q <= last_life ? LIVES_V : lives_q - 2'd1;
        end
    end
`else
    // Constant zero; the AND keeps LIVES referenced in this build.
    assign lives = LIVES_V & 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ctrl      <= decode(ST_IDLE);
            lvl       <= '0;
            flash_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (press) begin
                        state <= ST_PLAY;
                        ctrl  <= decode(ST_PLAY);
                        lvl   <= '0;
                    end
                end
                ST_PLAY: begin
                    if (press) begin
                        flash_cnt <= '0;
                        if (hit && lvl >= MAX_LVL_V) begin
                            state <= ST_WIN;
                            ctrl  <= decode(ST_WIN);
                        end else if (hit) begin
                            state <= ST_CORRECT;
                            ctrl  <= decode(ST_CORRECT);
                        end else begin
                            state <= ST_WRONG;
                            ctrl  <= decode(ST_WRONG);
                        end
                    end
                end
                ST_CORRECT: begin
                    if (flash_done) begin
                        state <= ST_PLAY;
                        ctrl  <= decode(ST_PLAY);
                        if (lvl < MAX_LVL_V) lvl <= lvl + 1'b1;
                    end else if (Cycle) begin
                        flash_cnt <= flash_cnt + 4'd1;
                    end
                end
                ST_WRONG: begin
                    if (flash_done) begin
                        state <= ST_PLAY;
                        ctrl  <= decode(ST_PLAY);
`ifdef GAME_LIVES_EN
                        if (last_life) lvl <= '0;
`else
                        lvl <= '0;
`endif
                    end else if (Cycle) begin
                        flash_cnt <= flash_cnt + 4'd1;
                    end
                end
                ST_WIN: begin
                    if (press) begin
                        state <= ST_IDLE;
                        ctrl  <= decode(ST_IDLE);
                        lvl   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ctrl  <= decode(ST_IDLE);
                    lvl   <= '0;
                end
            endcase
        end
    end

    assign Run          = ctrl.run;
    assign Normal       = ctrl.normal;
    assign FlashCorrect = ctrl.flash_correct;
    assign FlashWrong   = ctrl.flash_wrong;
    assign win          = ctrl.win;

endmodule
